// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
// Glyph patterns are active-low {g,f,e,d,c,b,a}; the dp bit sits above them in seg_out.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Index 15 first, so that SEG_PAT[n] is the glyph for hex digit n ("b" and "d" lower-case).
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low {g..a} segment pattern.
// Zero latency; no handshake.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_PAT[nibble_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver: double-buffered load port, PWM, dead time, blink, LZ blanking.
// Outputs registered one cycle after scan state; load_ready low while a word waits for the frame wrap.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_W        = 18,
  parameter int BRIGHT_W     = 3,
  parameter int DEAD_CYCLES  = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_en,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   seg_an,
  output logic [7:0]              seg_out,
  output logic                    frame_start
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_bl_q, pend_bl_d, act_bl_q, act_bl_d;
  logic                    pend_full_q, pend_full_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic                    started_q, started_d;
  logic [NUM_DIGITS-1:0]   seg_an_q, seg_an_d;
  logic [7:0]              seg_out_q, seg_out_d;
  logic                    frame_start_q, frame_start_d;

  logic       tick, wrap, accept;
  logic [3:0] cur_nib;
  logic [6:0] cur_pat;
  logic       upper_nz, lz_blank, lit;

  assign tick       = &pre_q;
  assign wrap       = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign load_ready = !pend_full_q;
  assign accept     = load_valid && load_ready;

  always_comb begin
    pre_d       = pre_q + 1'b1;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    pend_bl_d   = pend_bl_q;
    pend_full_d = pend_full_q;
    act_data_d  = act_data_q;
    act_en_d    = act_en_q;
    act_dp_d    = act_dp_q;
    act_bl_d    = act_bl_q;
    bcnt_d      = bcnt_q;
    blink_ph_d  = blink_ph_q;
    started_d   = started_q | wrap;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Copy decision uses pre-edge pend_full, so a same-cycle accept waits one more frame.
    if (wrap && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_en_d    = pend_en_q;
      act_dp_d    = pend_dp_q;
      act_bl_d    = pend_bl_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_data_d = load_data;
      pend_en_d   = load_en;
      pend_dp_d   = load_dp;
      pend_bl_d   = load_blink;
      pend_full_d = 1'b1;
    end

    if (wrap) begin
      if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt_d     = '0;
        blink_ph_d = !blink_ph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  assign cur_nib = act_data_q[idx_q*4 +: 4];

  seg_hex_decode u_dec (
    .nibble_i (cur_nib),
    .seg_n_o  (cur_pat)
  );

  // Any non-zero enabled digit at or above the current one defeats blanking.
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_q)) && act_en_q[j] && (act_data_q[j*4 +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
  end

  assign lz_blank = blank_lz && (idx_q != '0) && !upper_nz;

  always_comb begin
    lit = act_en_q[idx_q]
       && !(act_bl_q[idx_q] && blink_ph_q)
       && !lz_blank
       && (pre_q >= DIV_W'(DEAD_CYCLES))
       && (pre_q[DIV_W-1 -: BRIGHT_W] <= brightness);

    seg_an_d  = '1;
    seg_out_d = 8'hFF;
    if (lit) begin
      seg_an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_out_d = {!act_dp_q[idx_q], cur_pat};
    end
    frame_start_d = started_q && (idx_q == '0) && (pre_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pend_data_q   <= '0;
      pend_en_q     <= '0;
      pend_dp_q     <= '0;
      pend_bl_q     <= '0;
      pend_full_q   <= 1'b0;
      act_data_q    <= '0;
      act_en_q      <= '0;
      act_dp_q      <= '0;
      act_bl_q      <= '0;
      bcnt_q        <= '0;
      blink_ph_q    <= 1'b0;
      started_q     <= 1'b0;
      seg_an_q      <= '1;
      seg_out_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      pend_data_q   <= pend_data_d;
      pend_en_q     <= pend_en_d;
      pend_dp_q     <= pend_dp_d;
      pend_bl_q     <= pend_bl_d;
      pend_full_q   <= pend_full_d;
      act_data_q    <= act_data_d;
      act_en_q      <= act_en_d;
      act_dp_q      <= act_dp_d;
      act_bl_q      <= act_bl_d;
      bcnt_q        <= bcnt_d;
      blink_ph_q    <= blink_ph_d;
      started_q     <= started_d;
      seg_an_q      <= seg_an_d;
      seg_out_q     <= seg_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_an      = seg_an_q;
  assign seg_out     = seg_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs, a negedge monitor checks them.
module tb_seg_scan_mux;

  localparam int ND = 4, DW = 4, BW = 2, DEAD = 2, BF = 2;
  localparam int SLOT = 1 << DW;
  localparam int FRAME = SLOT * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_data = '0;
  logic [3:0]    load_en = '0, load_dp = '0, load_blink = '0;
  logic [BW-1:0] brightness = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    seg_an;
  logic [7:0]    seg_out;
  logic          frame_start;

  seg_scan_mux #(
    .NUM_DIGITS(ND), .DIV_W(DW), .BRIGHT_W(BW), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_en(load_en), .load_dp(load_dp), .load_blink(load_blink),
    .brightness(brightness), .blank_lz(blank_lz),
    .seg_an(seg_an), .seg_out(seg_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   seen_b0 = 0;

  // Active-high {g,f,e,d,c,b,a} glyphs for 0..F.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int         k = 0;
  logic [15:0] a_data = '0, p_data = '0;
  logic [3:0]  a_en = '0, a_dp = '0, a_bl = '0, p_en = '0, p_dp = '0, p_bl = '0;
  bit          p_full = 0;
  bit          acc_last = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference model: everything derives from k, the cycle count since reset release.
  always @(posedge clk) begin
    if (!rst) begin
      k = 0; p_full = 0; acc_last = 0;
      a_data = '0; a_en = '0; a_dp = '0; a_bl = '0;
      p_data = '0; p_en = '0; p_dp = '0; p_bl = '0;
    end else begin
      exp_t e;
      int pre, idx, frame;
      bit ph, lz, lit, acc;
      logic [3:0] nib;
      pre   = k % SLOT;
      idx   = (k / SLOT) % ND;
      frame = k / FRAME;
      ph    = ((frame / BF) % 2) == 1;
      nib   = a_data[idx*4 +: 4];
      lz    = blank_lz && (idx != 0);
      for (int j = idx; j < ND; j++)
        if (a_en[j] && a_data[j*4 +: 4] != 4'h0) lz = 0;
      lit = a_en[idx] && !(a_bl[idx] && ph) && !lz && (pre >= DEAD)
            && ((pre / (SLOT >> BW)) <= int'(brightness));
      e.an  = lit ? ~(4'(1) << idx) : 4'hF;
      e.seg = lit ? {~a_dp[idx], ~glyph[nib]} : 8'hFF;
      e.fs  = (k % FRAME == 0) && (k >= FRAME);
      acc = load_valid && !p_full;
      if ((k % FRAME == FRAME - 1) && p_full) begin
        a_data = p_data; a_en = p_en; a_dp = p_dp; a_bl = p_bl;
        p_full = 0;
      end
      if (acc) begin
        p_data = load_data; p_en = load_en; p_dp = load_dp; p_bl = load_blink;
        p_full = 1;
      end
      acc_last = acc;
      e.rdy = !p_full;
      q.push_back(e);
      k++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_an", seg_an, 4'hF);
      chk("rst_seg", seg_out, 8'hFF);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_rdy", load_ready, 1'b1);
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("seg_an", seg_an, e.an);
      chk("seg_out", seg_out, e.seg);
      chk("frame_start", frame_start, e.fs);
      chk("load_ready", load_ready, e.rdy);
      if (seg_an == 4'b1101 && seg_out == 8'hB0) seen_b0 = 1;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_async_an", seg_an, 4'hF);
    chk("rst_async_seg", seg_out, 8'hFF);
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] en, logic [3:0] dp, logic [3:0] bl);
    load_data = d; load_en = en; load_dp = dp; load_blink = bl;
    load_valid = 1'b1;
    for (int n = 0; n < 4 * FRAME; n++) begin
      @(posedge clk);
      #1;
      if (acc_last) begin
        load_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL load_timeout at %0t: got no accept expected accept within %0d cycles", $time, 4 * FRAME);
    load_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);
    brightness = 2'd3;
    wait_cyc(FRAME + 6);

    do_load(16'h1234, 4'hF, 4'h0, 4'h0);
    wait_cyc(2 * FRAME + 10);
    chk("digit1_glyph3", seen_b0, 1'b1);

    do_load(16'h1234, 4'hF, 4'h0, 4'h0);
    do_load(16'h00AB, 4'hF, 4'h0, 4'h0);
    wait_cyc(3 * FRAME);

    blank_lz = 1'b1;
    do_load(16'h0070, 4'hF, 4'h0, 4'h0);
    wait_cyc(2 * FRAME + 10);
    do_load(16'h0000, 4'hF, 4'h0, 4'h0);
    wait_cyc(2 * FRAME + 10);
    blank_lz = 1'b0;

    brightness = 2'd1;
    do_load(16'h5678, 4'hF, 4'h0, 4'h1);
    wait_cyc(5 * FRAME);
    brightness = 2'd3;

    do_load(16'h9ABC, 4'hF, 4'h2, 4'h0);
    wait_cyc(2 * FRAME + 10);

    for (int i = 0; i < 25; i++) begin
      brightness = BW'($urandom_range(0, 3));
      blank_lz = 1'($urandom_range(0, 1));
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      wait_cyc($urandom_range(0, 150));
      brightness = BW'($urandom_range(0, 3));
      wait_cyc($urandom_range(0, 40));
    end

    wait_cyc(5);
    do_reset(2);
    brightness = 2'd3;
    blank_lz = 1'b0;
    wait_cyc(FRAME + 10);
    do_load(16'hFEDC, 4'hF, 4'h5, 4'h0);
    wait_cyc(2 * FRAME + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
